// File: rtl/toggle_monitor.sv
// Measures high/low time of each full q_in period; results appear the cycle after the completing rise.
// Results are held under meas_ready backpressure; a period completing while a result is pending is dropped and flagged in lost.
module toggle_monitor #(
  parameter int CNT_W  = 8,
  parameter int EDGE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_in,
  input  logic              clr,
  input  logic              meas_ready,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  high_len,
  output logic [CNT_W-1:0]  low_len,
  output logic              sat,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              lost
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [EDGE_W-1:0] EDGE_ONE = {{(EDGE_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                q_dly_q, q_dly_d;
  logic [CNT_W-1:0]    hcnt_q, hcnt_d;
  logic [CNT_W-1:0]    lcnt_q, lcnt_d;
  logic                hsat_q, hsat_d;
  logic                lsat_q, lsat_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic                meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]    high_len_q, high_len_d;
  logic [CNT_W-1:0]    low_len_q, low_len_d;
  logic                sat_q, sat_d;
  logic                lost_q, lost_d;

  logic                rise;
  logic                fall;
  logic                capture;

  assign rise = q_in & ~q_dly_q;
  assign fall = ~q_in & q_dly_q;

  always_comb begin
    state_d      = state_q;
    q_dly_d      = q_in;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    hsat_d       = hsat_q;
    lsat_d       = lsat_q;
    edge_cnt_d   = edge_cnt_q;
    meas_valid_d = meas_valid_q;
    high_len_d   = high_len_q;
    low_len_d    = low_len_q;
    sat_d        = sat_q;
    lost_d       = lost_q;
    capture      = 1'b0;

    if (rise || fall) begin
      edge_cnt_d = edge_cnt_q + EDGE_ONE;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = CNT_ONE;
          hsat_d  = 1'b0;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          lcnt_d  = CNT_ONE;
          lsat_d  = 1'b0;
        end else if (hcnt_q == CNT_MAX) begin
          hsat_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + CNT_ONE;
        end
      end
      LOW: begin
        // The completing rise is also the first high sample of the next period.
        if (rise) begin
          capture = 1'b1;
          state_d = HIGH;
          hcnt_d  = CNT_ONE;
          hsat_d  = 1'b0;
        end else if (lcnt_q == CNT_MAX) begin
          lsat_d = 1'b1;
        end else begin
          lcnt_d = lcnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A result leaving this cycle frees the output registers for a same-cycle capture.
    if (capture) begin
      if (!meas_valid_q || meas_ready) begin
        meas_valid_d = 1'b1;
        high_len_d   = hcnt_q;
        low_len_d    = lcnt_q;
        sat_d        = hsat_q | lsat_q;
      end else begin
        lost_d = 1'b1;
      end
    end else if (meas_valid_q && meas_ready) begin
      meas_valid_d = 1'b0;
    end

    if (clr) begin
      state_d      = IDLE;
      q_dly_d      = 1'b0;
      hcnt_d       = '0;
      lcnt_d       = '0;
      hsat_d       = 1'b0;
      lsat_d       = 1'b0;
      edge_cnt_d   = '0;
      meas_valid_d = 1'b0;
      high_len_d   = '0;
      low_len_d    = '0;
      sat_d        = 1'b0;
      lost_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      q_dly_q      <= 1'b0;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      hsat_q       <= 1'b0;
      lsat_q       <= 1'b0;
      edge_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      high_len_q   <= '0;
      low_len_q    <= '0;
      sat_q        <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_dly_q      <= q_dly_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      hsat_q       <= hsat_d;
      lsat_q       <= lsat_d;
      edge_cnt_q   <= edge_cnt_d;
      meas_valid_q <= meas_valid_d;
      high_len_q   <= high_len_d;
      low_len_q    <= low_len_d;
      sat_q        <= sat_d;
      lost_q       <= lost_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign high_len   = high_len_q;
  assign low_len    = low_len_q;
  assign sat        = sat_q;
  assign edge_cnt   = edge_cnt_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor: an 8-bit-counter instance and a 4-bit-counter instance share one stimulus stream.
module tb_toggle_monitor;

  logic       clk;
  logic       rst;
  logic       q_in;
  logic       clr;
  logic       meas_ready;

  logic       v8, s8, lost8;
  logic [7:0] h8, l8, e8;
  logic       v4, s4, lost4;
  logic [3:0] h4, l4;
  logic [7:0] e4;

  int checks;
  int errors;

  toggle_monitor #(.CNT_W(8), .EDGE_W(8)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr), .meas_ready(meas_ready),
    .meas_valid(v8), .high_len(h8), .low_len(l8), .sat(s8), .edge_cnt(e8), .lost(lost8)
  );

  toggle_monitor #(.CNT_W(4), .EDGE_W(8)) dut4 (
    .clk(clk), .rst(rst), .q_in(q_in), .clr(clr), .meas_ready(meas_ready),
    .meas_valid(v4), .high_len(h4), .low_len(l4), .sat(s4), .edge_cnt(e4), .lost(lost4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       q;
    logic       rdy;
    logic       v;
    logic [7:0] h;
    logic [7:0] l;
    logic       lost;
    logic [7:0] e;
  } vec_t;

  vec_t tbl [29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic q, input logic c, input logic r);
    q_in       = q;
    clr        = c;
    meas_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, ".valid"}, v8, 0);
    chk({tag, ".high"}, h8, 0);
    chk({tag, ".low"}, l8, 0);
    chk({tag, ".sat"}, s8, 0);
    chk({tag, ".edge"}, e8, 0);
    chk({tag, ".lost"}, lost8, 0);
  endtask

  logic [7:0] exp_e;
  logic       tq;

  initial begin
    checks = 0;
    errors = 0;

    //        q     rdy   v     h  l  lost e
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 2};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 2};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 3, 2, 1'b0, 3};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 3};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 3};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 4};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 4};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 4};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 4};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 4, 4, 1'b0, 5};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 4, 4, 1'b0, 5};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 4, 4, 1'b0, 6};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 4, 4, 1'b0, 6};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 4, 4, 1'b0, 6};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 4, 4, 1'b0, 6};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 4, 4, 1'b0, 6};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 4, 4, 1'b0, 6};
    tbl[22] = '{1'b1, 1'b0, 1'b1, 4, 4, 1'b1, 7};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 7};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 8};
    tbl[25] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 8};
    tbl[26] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 8};
    tbl[27] = '{1'b1, 1'b1, 1'b1, 2, 3, 1'b1, 9};
    tbl[28] = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 9};

    rst        = 1'b0;
    q_in       = 1'b0;
    clr        = 1'b0;
    meas_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero8("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic period and backpressure, one row per clock.
    for (int i = 0; i < 29; i++) begin
      step(tbl[i].q, 1'b0, tbl[i].rdy);
      chk($sformatf("tbl%0d.valid", i), v8, tbl[i].v);
      chk($sformatf("tbl%0d.lost", i), lost8, tbl[i].lost);
      chk($sformatf("tbl%0d.edge", i), e8, tbl[i].e);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d.high", i), h8, tbl[i].h);
        chk($sformatf("tbl%0d.low", i), l8, tbl[i].l);
        chk($sformatf("tbl%0d.sat", i), s8, 0);
      end
    end

    // Asynchronous reset while in LOW with lcnt=3.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("premid.edge", e8, 10);
    #2 rst = 1'b0;
    #1;
    chk_zero8("async_rst");
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_held.edge", e8, 0);
    chk("rst_held.valid", v8, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    chk("rel0.valid", v8, 0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rel_fall.valid", v8, 0);
    chk("rel_fall.edge", e8, 2);
    step(1'b1, 1'b0, 1'b1);
    chk("rel_cap.valid", v8, 1);
    chk("rel_cap.high", h8, 2);
    chk("rel_cap.low", l8, 1);
    chk("rel_cap.edge", e8, 3);
    chk("rel_cap.lost", lost8, 0);

    // Fastest toggle: 1/1 results every other cycle, edge_cnt wraps through 0.
    exp_e = 8'd3;
    for (int i = 1; i <= 260; i++) begin
      tq    = (i % 2 == 0);
      exp_e = exp_e + 8'd1;
      step(tq, 1'b0, 1'b1);
      chk($sformatf("tog%0d.edge", i), e8, exp_e);
      chk($sformatf("tog%0d.valid", i), v8, tq);
      if (tq) begin
        chk($sformatf("tog%0d.high", i), h8, 1);
        chk($sformatf("tog%0d.low", i), l8, 1);
      end
    end

    // Saturation on the 4-bit instance.
    step(1'b0, 1'b1, 1'b1);
    chk("sclr.valid4", v4, 0);
    chk("sclr.edge4", e4, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("sat_pre.valid4", v4, 0);
    step(1'b1, 1'b0, 1'b1);
    chk("sat.valid4", v4, 1);
    chk("sat.high4", h4, 15);
    chk("sat.low4", l4, 2);
    chk("sat.sat4", s4, 1);
    chk("sat.edge4", e4, 3);
    chk("sat.high8", h8, 20);
    chk("sat.sat8", s8, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("after_sat.valid4", v4, 1);
    chk("after_sat.high4", h4, 5);
    chk("after_sat.low4", l4, 5);
    chk("after_sat.sat4", s4, 0);
    chk("after_sat.edge4", e4, 5);

    // clr during HIGH with hcnt=5, meas_valid=1 and lost=1.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("preclr.lost", lost8, 1);
    chk("preclr.valid", v8, 1);
    chk("preclr.high", h8, 5);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_zero8("clr");
    step(1'b1, 1'b0, 1'b1);
    chk("pclr_rise.edge", e8, 1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("pclr_low.valid", v8, 0);
    step(1'b1, 1'b0, 1'b1);
    chk("pclr_cap.valid", v8, 1);
    chk("pclr_cap.high", h8, 2);
    chk("pclr_cap.low", l8, 2);
    chk("pclr_cap.edge", e8, 3);
    chk("pclr_cap.lost", lost8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
